// File: rtl/ram_event_reader.sv
// Read-side sequencer for the event buffer RAM: issues credit-limited burst reads and
// repacks returned words into a valid/ready stream. Optional header word: READER_HEADER_EN.
module ram_event_reader #(
    parameter int RAM_DEPTH  = 230001,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        rd_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] base_addr,
    input  logic [17:0] word_cnt,
    output logic [17:0] rd_addr,
    output logic        rd_ena,
    input  logic [31:0] q,
    input  logic        dval,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [17:0] ADDR_MAX = 18'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [17:0]     rd_addr_q, rd_addr_d;
    logic [17:0]     rem_q, rem_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [32:0]     fifo_mem [FIFO_DEPTH];

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            hdr_push;
    logic [32:0]     push_word;
    logic [32:0]     head;
    logic [CW:0]     occ;

`ifdef READER_HEADER_EN
    logic            hdr_pending_q, hdr_pending_d;
    logic [17:0]     cnt_q, cnt_d;
`endif

    always_comb begin
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        rem_d           = rem_q;
        inflight_last_d = inflight_last_q;
        rd_ena          = 1'b0;
        push            = 1'b0;
        hdr_push        = 1'b0;
        push_word       = '0;
`ifdef READER_HEADER_EN
        hdr_pending_d   = hdr_pending_q;
        cnt_d           = cnt_q;
`endif

        fifo_empty = (count_q == '0);
        head       = fifo_mem[rd_ptr_q];
        pop        = !fifo_empty && out_ready;

        // Only a word we actually asked for may enter the FIFO.
        if (dval && inflight_q) begin
            push      = 1'b1;
            push_word = {inflight_last_q, q};
        end

`ifdef READER_HEADER_EN
        if (state_q == S_READ && hdr_pending_q) begin
            hdr_push      = 1'b1;
            push          = 1'b1;
            push_word     = {(cnt_q == 18'd0), 8'hA5, 6'b0, cnt_q};
            hdr_pending_d = 1'b0;
        end
`endif

        // Credit: words stored, the one outstanding read and a header being written now.
        occ = (CW+1)'(count_q) + (CW+1)'(inflight_q) + (CW+1)'(hdr_push);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d = base_addr;
                    rem_d     = word_cnt;
`ifdef READER_HEADER_EN
                    cnt_d         = word_cnt;
                    hdr_pending_d = 1'b1;
                    state_d       = S_READ;
`else
                    state_d   = (word_cnt == 18'd0) ? S_DONE : S_READ;
`endif
                end
            end
            S_READ: begin
                if (rem_q != 18'd0 && occ < (CW+1)'(FIFO_DEPTH)) begin
                    rd_ena          = 1'b1;
                    rem_d           = rem_q - 18'd1;
                    rd_addr_d       = (rd_addr_q == ADDR_MAX) ? 18'd0 : rd_addr_q + 18'd1;
                    inflight_last_d = (rem_q == 18'd1);
                    if (rem_q == 18'd1) begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef READER_HEADER_EN
                if (rem_q == 18'd0 && hdr_push) begin
                    state_d = S_DRAIN;
                end
`endif
            end
            S_DRAIN: begin
                if ((pop && head[32]) || (fifo_empty && !inflight_q)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d = rd_ena ? 1'b1 : (dval ? 1'b0 : inflight_q);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rd_addr_q       <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

`ifdef READER_HEADER_EN
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            hdr_pending_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            hdr_pending_q <= hdr_pending_d;
            cnt_q         <= cnt_d;
        end
    end
`endif

    always_ff @(posedge rd_clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    // Stale storage is masked so an empty FIFO always presents zeros.
    assign rd_addr   = rd_addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'd0 : head[31:0];
    assign out_last  = !fifo_empty && head[32];
    assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_event_reader.sv
// Scoreboard bench for ram_event_reader: directed bursts against a one-cycle-latency RAM
// model holding ram[i]=i; a negedge monitor pops expected words and checks done/credit.
module tb_ram_event_reader;

    localparam int RAM_DEPTH  = 230001;
    localparam int FIFO_DEPTH = 4;
`ifdef READER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] base_addr = '0;
    logic [17:0] word_cnt = '0;
    logic [17:0] rd_addr;
    logic        rd_ena;
    logic [31:0] q = '0;
    logic        dval = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        stray_req = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int word_no = 0;
    logic [32:0] exp_q[$];

    always #5 rd_clk = ~rd_clk;

    ram_event_reader #(.RAM_DEPTH(RAM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .rd_clk(rd_clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .rd_addr(rd_addr), .rd_ena(rd_ena), .q(q), .dval(dval),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    // RAM model: ram[i] = i, one-cycle latency; stray_req injects an unrequested dval.
    always @(posedge rd_clk) begin
        dval <= rd_ena | stray_req;
        if (rd_ena) q <= {14'd0, rd_addr};
        else if (stray_req) q <= 32'hDEADBEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: stream scoreboard, done-after-last and credit bound.
    bit prev_last = 1'b0;
    bit busy_prev = 1'b0;
    int occ = 0;
    always @(negedge rd_clk) begin
        if (rst) begin
            occ = 0;
            prev_last = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (prev_last) check("done_after_last", {62'd0, done, busy}, 64'b10);
            if (done) done_cnt++;
            if (busy && !busy_prev && HDR) occ++;
            if (busy) begin
                checks++;
                if (occ > FIFO_DEPTH) begin
                    errors++;
                    $display("FAIL occupancy: actual %0d expected at most %0d", occ, FIFO_DEPTH);
                end
            end
            prev_last = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: actual %h/%b expected none", out_data, out_last);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    $display("word %0d: data=%h last=%b", word_no, out_data, out_last);
                    check("stream_word", {31'd0, out_last, out_data}, {31'd0, e});
                end
                word_no++;
                prev_last = out_last;
                occ--;
            end
            if (rd_ena) occ++;
            busy_prev = busy;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_burst(input int b, input int w);
        if (HDR) exp_q.push_back({(w == 0), 8'hA5, 6'b0, 18'(w)});
        for (int i = 0; i < w; i++) begin
            int a;
            a = (b + i) % RAM_DEPTH;
            exp_q.push_back({(i == w - 1), 32'(a)});
        end
    endtask

    task automatic do_start(input int b, input int w);
        start = 1'b1;
        base_addr = 18'(b);
        word_cnt = 18'(w);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual no done expected done within %0d cycles", max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        bit saw_ena;
        bit saw_valid;

        // Reset state
        repeat (3) tick();
        check("rst_rd_ena", rd_ena, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy_done", {busy, done}, 0);
        rst = 1'b0;
        tick();

        // Basic burst and start latency
        d0 = done_cnt;
        push_burst(10, 5);
        do_start(10, 5);
        check("lat_rd_ena", rd_ena, 1);
        check("lat_rd_addr", rd_addr, 10);
        check("lat_busy", busy, 1);
        tick();
        check("lat_valid_c2", out_valid, HDR);
        tick();
        check("lat_valid_c3", {out_valid, out_data}, {1'b1, 32'd10});
        wait_done(50, n);
        check("basic_done_cycle", n + 2, 7);
        tick();
        check("basic_done_count", done_cnt - d0, 1);

        // Address wrap on RAM_DEPTH
        push_burst(230000, 3);
        do_start(230000, 3);
        wait_done(50, n);
        tick();

        // Backpressure: ready 1 cycle on, 3 off
        d0 = done_cnt;
        push_burst(1000, 20);
        do_start(1000, 20);
        n = 0;
        while (!done && n < 400) begin
            out_ready = (n % 4 == 0);
            tick();
            n++;
        end
        check("bp_done_seen", done, 1);
        out_ready = 1'b1;
        tick();
        check("bp_done_count", done_cnt - d0, 1);
        check("bp_drained", exp_q.size(), 0);

        // Zero length
        d0 = done_cnt;
        push_burst(5, 0);
        do_start(5, 0);
        if (!HDR) check("zero_done_c1", {done, busy}, 2'b10);
        saw_ena = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rd_ena) saw_ena = 1'b1;
            if (out_valid) saw_valid = 1'b1;
            tick();
        end
        check("zero_no_rd_ena", saw_ena, 0);
        check("zero_valid_seen", saw_valid, HDR);
        check("zero_done_count", done_cnt - d0, 1);

        // Reset mid-burst, then stray dval, then a fresh burst
        out_ready = 1'b0;
        push_burst(100, 10);
        do_start(100, 10);
        check("mid_rd_ena", rd_ena, 1);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_rd_ena", rd_ena, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_outs", {out_valid, out_last, busy, done}, 0);
        check("mid_rst_data", out_data, 0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        repeat (2) tick();
        check("mid_stray_dropped", out_valid, 0);
        out_ready = 1'b1;
        d0 = done_cnt;
        push_burst(0, 2);
        do_start(0, 2);
        wait_done(50, n);
        tick();
        check("mid_fresh_done_count", done_cnt - d0, 1);

        // Start while busy is ignored
        d0 = done_cnt;
        push_burst(40, 6);
        do_start(40, 6);
        tick();
        start = 1'b1;
        base_addr = 18'd200;
        word_cnt = 18'd3;
        tick();
        start = 1'b0;
        wait_done(50, n);
        repeat (6) tick();
        check("busy_start_idle", busy, 0);
        check("busy_start_done_count", done_cnt - d0, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
